// File: rtl/risc_pkg.sv
// Shared RISC constants: opcodes, function codes, ALU control codes
// and the issue FSM state type.
package risc_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LB    = 6'd32;
    localparam logic [5:0] OP_SB    = 6'd40;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;

    // ALU control codes: {6'd0, funct} for R-type, {op, 6'd0} for I-type
    localparam logic [11:0] ALU_ADD  = 12'd32;
    localparam logic [11:0] ALU_ADDI = 12'd512;
    localparam logic [11:0] ALU_SUB  = 12'd34;
    localparam logic [11:0] ALU_MUL  = 12'd24;
    localparam logic [11:0] ALU_DIV  = 12'd26;
    localparam logic [11:0] ALU_AND  = 12'd36;
    localparam logic [11:0] ALU_ANDI = 12'd768;
    localparam logic [11:0] ALU_OR   = 12'd37;
    localparam logic [11:0] ALU_ORI  = 12'd832;
    localparam logic [11:0] ALU_LB   = 12'd2048;
    localparam logic [11:0] ALU_SB   = 12'd2560;

    // Issue sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue handshake, ALU operand buses and writeback handshake.
// Both handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; the sender holds valid and its payload stable until
// that edge, and ready never depends combinationally on valid.
interface alu_issue_ctrl_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instr;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [W-1:0] alu_rs;
    logic [W-1:0] alu_rt;
    logic [W-1:0] alu_imm;
    logic [11:0]  alu_cnt;
    logic [W-1:0] alu_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [4:0]   res_dest;
    logic         res_wen;
    logic         res_illegal;

    // Issue controller side
    modport master (
        input  in_valid, instr, rs_data, rt_data, alu_out, res_ready,
        output in_ready, alu_rs, alu_rt, alu_imm, alu_cnt,
               res_valid, res_data, res_dest, res_wen, res_illegal
    );

    // Register file / ALU / writeback side
    modport slave (
        output in_valid, instr, rs_data, rt_data, alu_out, res_ready,
        input  in_ready, alu_rs, alu_rt, alu_imm, alu_cnt,
               res_valid, res_data, res_dest, res_wen, res_illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of one instruction word into ALU control code,
// extended immediate, destination register and write/illegal/latency flags.
module alu_ctrl_decode
    import risc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [31:0]  instr,
    output logic [11:0]  cnt,
    output logic [W-1:0] imm_ext,
    output logic [4:0]   dest,
    output logic         wen,
    output logic         illegal,
    output logic         is_muldiv
);
    logic [5:0]   op;
    logic [5:0]   funct;
    logic [15:0]  imm;
    logic [W-1:0] imm_sx;
    logic [W-1:0] imm_zx;
    logic         is_store;
    logic         unused_rs_field;

    assign op     = instr[31:26];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign imm_sx = {{(W-16){imm[15]}}, imm};
    assign imm_zx = {{(W-16){1'b0}}, imm};
    // The rs field only selects the register-file read upstream.
    assign unused_rs_field = ^instr[25:21];

    // Map opcode/funct to control code; anything unlisted is illegal with code 0.
    always_comb begin
        cnt       = '0;
        imm_ext   = '0;
        illegal   = 1'b0;
        is_muldiv = 1'b0;
        is_store  = 1'b0;
        dest      = (op == OP_RTYPE) ? instr[15:11] : instr[20:16];
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  cnt = ALU_ADD;
                FN_SUB:  cnt = ALU_SUB;
                FN_AND:  cnt = ALU_AND;
                FN_OR:   cnt = ALU_OR;
                FN_MULT: begin cnt = ALU_MUL; is_muldiv = 1'b1; end
                FN_DIV:  begin cnt = ALU_DIV; is_muldiv = 1'b1; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (op)
                OP_ADDI: begin cnt = ALU_ADDI; imm_ext = imm_sx; end
                OP_ANDI: begin cnt = ALU_ANDI; imm_ext = imm_zx; end
                OP_ORI:  begin cnt = ALU_ORI;  imm_ext = imm_zx; end
                OP_LB:   begin cnt = ALU_LB;   imm_ext = imm_sx; end
                OP_SB:   begin cnt = ALU_SB;   imm_ext = imm_sx; is_store = 1'b1; end
                default: illegal = 1'b1;
            endcase
        end
        wen = !illegal && !is_store && (dest != 5'd0);
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end: accepts one instruction, holds the ALU inputs
// for the op latency, captures the result and offers it to writeback.
module alu_issue_ctrl
    import risc_pkg::*;
#(
    parameter int W          = 32,
    parameter int LAT_BASIC  = 1,
    parameter int LAT_MULDIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.master  bus,
    output issue_state_t      dbg_state
);
    localparam int LAT_MAX = (LAT_MULDIV > LAT_BASIC) ? LAT_MULDIV : LAT_BASIC;
    localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CW-1:0] LEFT_BASIC  = CW'(LAT_BASIC - 1);
    localparam logic [CW-1:0] LEFT_MULDIV = CW'(LAT_MULDIV - 1);

    issue_state_t state;
    logic [CW-1:0] cnt_left;
    logic          div0_q;

    logic [W-1:0] alu_rs_q, alu_rt_q, alu_imm_q, res_data_q;
    logic [11:0]  alu_cnt_q;
    logic [4:0]   res_dest_q;
    logic         res_wen_q, res_illegal_q;

    logic [11:0]  dec_cnt;
    logic [W-1:0] dec_imm;
    logic [4:0]   dec_dest;
    logic         dec_wen, dec_illegal, dec_muldiv;
    logic         div_by_zero;

    alu_ctrl_decode #(.W(W)) u_decode (
        .instr     (bus.instr),
        .cnt       (dec_cnt),
        .imm_ext   (dec_imm),
        .dest      (dec_dest),
        .wen       (dec_wen),
        .illegal   (dec_illegal),
        .is_muldiv (dec_muldiv)
    );

    // A div with a zero divisor never reaches the ALU; its result is forced.
    assign div_by_zero = (dec_cnt == ALU_DIV) && (bus.rt_data == '0);

    // Issue FSM, latency counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt_left      <= '0;
            div0_q        <= 1'b0;
            alu_rs_q      <= '0;
            alu_rt_q      <= '0;
            alu_imm_q     <= '0;
            alu_cnt_q     <= '0;
            res_data_q    <= '0;
            res_dest_q    <= '0;
            res_wen_q     <= 1'b0;
            res_illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        alu_rs_q      <= bus.rs_data;
                        alu_rt_q      <= bus.rt_data;
                        alu_imm_q     <= dec_imm;
                        alu_cnt_q     <= div_by_zero ? 12'd0 : dec_cnt;
                        div0_q        <= div_by_zero;
                        res_dest_q    <= dec_dest;
                        res_wen_q     <= dec_wen;
                        res_illegal_q <= dec_illegal;
                        cnt_left      <= dec_muldiv ? LEFT_MULDIV : LEFT_BASIC;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_left != '0) begin
                        cnt_left <= cnt_left - CW'(1);
                    end else begin
                        res_data_q <= res_illegal_q ? '0 : (div0_q ? '1 : bus.alu_out);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        alu_rs_q  <= '0;
                        alu_rt_q  <= '0;
                        alu_imm_q <= '0;
                        alu_cnt_q <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.alu_rs      = alu_rs_q;
    assign bus.alu_rt      = alu_rt_q;
    assign bus.alu_imm     = alu_imm_q;
    assign bus.alu_cnt     = alu_cnt_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_dest    = res_dest_q;
    assign bus.res_wen     = res_wen_q;
    assign bus.res_illegal = res_illegal_q;
    assign dbg_state       = state;
endmodule
